// File: rtl/hci_core_per_arbiter.sv
// rtl/hci_core_per_arbiter.sv - round-robin N:1 arbiter onto one peripheral port with in-order response routing
// Optional feature macro: HCI_PER_ARB_ERR_EN (sticky orphan-response flag on err_o)
module hci_core_per_arbiter #(
  parameter int NB_IN           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int AW              = 32,  // default hci address width
  parameter int DW              = 32,
  parameter int UW              = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  // requester ports
  input  logic [NB_IN-1:0]               slave_req,
  output logic [NB_IN-1:0]               slave_gnt,
  input  logic [NB_IN-1:0][AW-1:0]       slave_add,
  input  logic [NB_IN-1:0]               slave_wen,
  input  logic [NB_IN-1:0][DW-1:0]       slave_data,
  input  logic [NB_IN-1:0][DW/8-1:0]     slave_be,
  input  logic [NB_IN-1:0]               slave_lrdy,
  input  logic [NB_IN-1:0][UW-1:0]       slave_user,
  output logic [NB_IN-1:0]               slave_r_valid,
  output logic [NB_IN-1:0][DW-1:0]       slave_r_data,
  output logic [NB_IN-1:0]               slave_r_opc,
  output logic [NB_IN-1:0][UW-1:0]       slave_r_user,
  // shared peripheral port
  output logic                           master_req,
  input  logic                           master_gnt,
  output logic [AW-1:0]                  master_add,
  output logic                           master_wen,
  output logic [DW-1:0]                  master_data,
  output logic [DW/8-1:0]                master_be,
  output logic                           master_lrdy,
  output logic [UW-1:0]                  master_user,
  input  logic                           master_r_valid,
  input  logic [DW-1:0]                  master_r_data,
  input  logic                           master_r_opc,
  input  logic [UW-1:0]                  master_r_user,
  output logic                           err_o
);

  localparam int IW = $clog2(NB_IN);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [IW-1:0] prio_q;
  logic [IW-1:0] prio_d;
  logic [IW-1:0] winner;
  logic          any_req;
  logic [IW:0]   rr_sum;
  logic [IW-1:0] rr_cand;

  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;

  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Round-robin pick: first requester at or after prio_q, wrapping modulo NB_IN.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    rr_sum  = '0;
    rr_cand = '0;
    for (int i = 0; i < NB_IN; i++) begin
      rr_sum = {1'b0, prio_q} + (IW+1)'(i);
      if (rr_sum >= (IW+1)'(NB_IN)) begin
        rr_sum = rr_sum - (IW+1)'(NB_IN);
      end
      rr_cand = rr_sum[IW-1:0];
      if (!any_req && slave_req[rr_cand]) begin
        any_req = 1'b1;
        winner  = rr_cand;
      end
    end
  end

  // Priority moves just past the winner once it has been accepted.
  assign prio_d = (winner == IW'(NB_IN - 1)) ? '0 : winner + 1'b1;

  // Request is withheld while every routing slot is in use.
  assign master_req = any_req & ~fifo_full;
  assign push       = master_req & master_gnt;
  assign pop        = master_r_valid & ~fifo_empty;

  // Winner's request fields go to the shared port; all zero when idle.
  always_comb begin
    master_add  = '0;
    master_wen  = 1'b0;
    master_data = '0;
    master_be   = '0;
    master_lrdy = 1'b0;
    master_user = '0;
    if (any_req) begin
      master_add  = slave_add[winner];
      master_wen  = slave_wen[winner];
      master_data = slave_data[winner];
      master_be   = slave_be[winner];
      master_lrdy = slave_lrdy[winner];
      master_user = slave_user[winner];
    end
  end

  // Grant only the winner, and never while reset is asserted.
  always_comb begin
    slave_gnt = '0;
    if (push && !rst_i) begin
      slave_gnt[winner] = 1'b1;
    end
  end

  // Response goes straight to the requester at the FIFO head in the same cycle.
  always_comb begin
    slave_r_valid = '0;
    slave_r_data  = '0;
    slave_r_opc   = '0;
    slave_r_user  = '0;
    if (pop && !rst_i) begin
      slave_r_valid[head] = 1'b1;
      slave_r_data[head]  = master_r_data;
      slave_r_opc[head]   = master_r_opc;
      slave_r_user[head]  = master_r_user;
    end
  end

  // Arbitration pointer and routing-FIFO bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      prio_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        prio_q   <= prio_d;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Routing storage; count_q gates every read, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= winner;
    end
  end

`ifdef HCI_PER_ARB_ERR_EN
  logic err_q;

  // Sticky flag for responses that arrive with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (clear_i) begin
      err_q <= 1'b0;
    end else if (master_r_valid && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hci_core_per_arbiter.sv
// tb/tb_hci_core_per_arbiter.sv - self-checking bench for hci_core_per_arbiter
module tb_hci_core_per_arbiter;

  localparam int NB = 4;
  localparam int MO = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int UW = 2;
  localparam logic [NB-1:0] ONE = 1;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      clear_i;
  logic [NB-1:0]             slave_req, slave_gnt, slave_wen, slave_lrdy, slave_r_valid, slave_r_opc;
  logic [NB-1:0][AW-1:0]     slave_add;
  logic [NB-1:0][DW-1:0]     slave_data, slave_r_data;
  logic [NB-1:0][DW/8-1:0]   slave_be;
  logic [NB-1:0][UW-1:0]     slave_user, slave_r_user;
  logic                      master_req, master_gnt, master_wen, master_lrdy;
  logic                      master_r_valid, master_r_opc, err_o;
  logic [AW-1:0]             master_add;
  logic [DW-1:0]             master_data, master_r_data;
  logic [DW/8-1:0]           master_be;
  logic [UW-1:0]             master_user, master_r_user;

  int checks = 0;
  int errors = 0;

  // reference model: priority pointer, queue of granted requester ids, sticky error
  int m_prio = 0;
  int m_q[$];
  bit m_err = 0;

  hci_core_per_arbiter #(
    .NB_IN(NB), .MAX_OUTSTANDING(MO), .AW(AW), .DW(DW), .UW(UW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .slave_req(slave_req), .slave_gnt(slave_gnt), .slave_add(slave_add),
    .slave_wen(slave_wen), .slave_data(slave_data), .slave_be(slave_be),
    .slave_lrdy(slave_lrdy), .slave_user(slave_user),
    .slave_r_valid(slave_r_valid), .slave_r_data(slave_r_data),
    .slave_r_opc(slave_r_opc), .slave_r_user(slave_r_user),
    .master_req(master_req), .master_gnt(master_gnt), .master_add(master_add),
    .master_wen(master_wen), .master_data(master_data), .master_be(master_be),
    .master_lrdy(master_lrdy), .master_user(master_user),
    .master_r_valid(master_r_valid), .master_r_data(master_r_data),
    .master_r_opc(master_r_opc), .master_r_user(master_r_user),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int model_winner(input logic [NB-1:0] reqs, input int prio);
    for (int k = 0; k < NB; k++) begin
      int j;
      j = (prio + k) % NB;
      if (reqs[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit exp_err();
`ifdef HCI_PER_ARB_ERR_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_prio = 0;
    m_err  = 0;
  endtask

  task automatic model_update();
    int w;
    bit hs, pp;
    if (clear_i) begin
      model_reset();
      return;
    end
    w  = model_winner(slave_req, m_prio);
    hs = (w >= 0) && (m_q.size() < MO) && master_gnt;
    pp = master_r_valid && (m_q.size() > 0);
    if (master_r_valid && m_q.size() == 0) m_err = 1;
    if (pp) void'(m_q.pop_front());
    if (hs) begin
      m_q.push_back(w);
      m_prio = (w + 1) % NB;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    slave_req      = '0;
    slave_add      = '0;
    slave_wen      = '0;
    slave_data     = '0;
    slave_be       = '0;
    slave_lrdy     = '1;
    slave_user     = '0;
    master_gnt     = 1'b0;
    master_r_valid = 1'b0;
    master_r_data  = '0;
    master_r_opc   = 1'b0;
    master_r_user  = '0;
  endtask

  task automatic drain();
    int guard = 0;
    slave_req  = '0;
    master_gnt = 1'b0;
    while (m_q.size() > 0 && guard < 2 * MO) begin
      master_r_valid = 1'b1;
      master_r_data  = $urandom;
      @(negedge clk_i);
      checks++;
      if (slave_r_valid !== (ONE << m_q[0])) begin
        errors++;
        $display("FAIL drain_r_valid: got %b expected %b", slave_r_valid, ONE << m_q[0]);
      end
      tick();
      guard++;
    end
    master_r_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_i = 1'b0;
    idle_inputs();
    slave_req      = '1;
    master_gnt     = 1'b1;
    master_r_valid = 1'b1;
    master_r_data  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    checks++;
    if (slave_gnt !== '0) begin
      errors++; $display("FAIL reset_gnt: got %b expected 0000", slave_gnt);
    end
    checks++;
    if (slave_r_valid !== '0) begin
      errors++; $display("FAIL reset_r_valid: got %b expected 0000", slave_r_valid);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", err_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (master_req !== 1'b0 || master_add !== '0) begin
      errors++; $display("FAIL idle_master: got req=%b add=%h expected req=0 add=0", master_req, master_add);
    end
    tick();
  endtask

  task automatic test_fairness();
    int order[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NB; i++) slave_add[i] = 32'h1000 * (i + 1);
    for (int c = 0; c < 5; c++) begin
      slave_req      = '1;
      master_gnt     = 1'b1;
      master_r_valid = (c > 0);
      master_r_data  = $urandom;
      @(negedge clk_i);
      checks++;
      if (slave_gnt !== (ONE << order[c])) begin
        errors++; $display("FAIL fair_gnt[%0d]: got %b expected %b", c, slave_gnt, ONE << order[c]);
      end
      checks++;
      if (master_add !== 32'h1000 * (order[c] + 1)) begin
        errors++; $display("FAIL fair_add[%0d]: got %h expected %h", c, master_add, 32'h1000 * (order[c] + 1));
      end
      if (c > 0) begin
        checks++;
        if (slave_r_valid !== (ONE << order[c-1]) || slave_r_data[order[c-1]] !== master_r_data) begin
          errors++;
          $display("FAIL fair_resp[%0d]: got valid=%b data=%h expected valid=%b data=%h",
                   c, slave_r_valid, slave_r_data[order[c-1]], ONE << order[c-1], master_r_data);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_full_fifo();
    slave_req      = 4'b0010;
    master_gnt     = 1'b1;
    master_r_valid = 1'b0;
    for (int c = 0; c < MO; c++) begin
      @(negedge clk_i);
      checks++;
      if (master_req !== 1'b1 || slave_gnt !== 4'b0010) begin
        errors++; $display("FAIL full_fill[%0d]: got req=%b gnt=%b expected req=1 gnt=0010", c, master_req, slave_gnt);
      end
      tick();
    end
    @(negedge clk_i);
    checks++;
    if (master_req !== 1'b0 || slave_gnt !== 4'b0000) begin
      errors++; $display("FAIL full_block: got req=%b gnt=%b expected req=0 gnt=0000", master_req, slave_gnt);
    end
    tick();
    master_r_valid = 1'b1;
    master_r_data  = 32'h1234_5678;
    @(negedge clk_i);
    checks++;
    if (master_req !== 1'b0 || slave_r_valid !== 4'b0010) begin
      errors++; $display("FAIL full_pop: got req=%b r_valid=%b expected req=0 r_valid=0010", master_req, slave_r_valid);
    end
    tick();
    master_r_valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if (master_req !== 1'b1) begin
      errors++; $display("FAIL full_reenable: got req=%b expected 1", master_req);
    end
    tick();
    drain();
  endtask

  task automatic test_routing();
    slave_add[2] = 32'h100; slave_wen[2] = 1'b1;
    slave_add[0] = 32'h200; slave_wen[0] = 1'b1;
    slave_req  = 4'b0100;
    master_gnt = 1'b1;
    @(negedge clk_i);
    checks++;
    if (slave_gnt !== 4'b0100 || master_add !== 32'h100) begin
      errors++; $display("FAIL route_req2: got gnt=%b add=%h expected gnt=0100 add=100", slave_gnt, master_add);
    end
    tick();
    slave_req = 4'b0001;
    @(negedge clk_i);
    checks++;
    if (slave_gnt !== 4'b0001 || master_add !== 32'h200) begin
      errors++; $display("FAIL route_req0: got gnt=%b add=%h expected gnt=0001 add=200", slave_gnt, master_add);
    end
    tick();
    slave_req      = '0;
    master_gnt     = 1'b0;
    master_r_valid = 1'b1;
    master_r_data  = 32'hAAAA;
    @(negedge clk_i);
    checks++;
    if (slave_r_valid !== 4'b0100 || slave_r_data[2] !== 32'hAAAA || slave_r_data[0] !== '0) begin
      errors++; $display("FAIL route_resp2: got valid=%b d2=%h d0=%h expected valid=0100 d2=aaaa d0=0",
                         slave_r_valid, slave_r_data[2], slave_r_data[0]);
    end
    tick();
    master_r_data = 32'hBBBB;
    @(negedge clk_i);
    checks++;
    if (slave_r_valid !== 4'b0001 || slave_r_data[0] !== 32'hBBBB) begin
      errors++; $display("FAIL route_resp0: got valid=%b d0=%h expected valid=0001 d0=bbbb", slave_r_valid, slave_r_data[0]);
    end
    tick();
    master_r_valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if (slave_r_valid !== 4'b0000) begin
      errors++; $display("FAIL route_single: got %b expected 0000", slave_r_valid);
    end
    tick();
  endtask

  task automatic test_orphan();
    master_r_valid = 1'b1;
    master_r_data  = 32'hCAFE;
    @(negedge clk_i);
    checks++;
    if (slave_r_valid !== 4'b0000) begin
      errors++; $display("FAIL orphan_drop: got %b expected 0000", slave_r_valid);
    end
    tick();
    master_r_valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if (err_o !== exp_err()) begin
      errors++; $display("FAIL orphan_err: got %b expected %b", err_o, exp_err());
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL clear_err: got %b expected 0", err_o);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    master_r_valid = 1'b1;
    tick();
    master_r_valid = 1'b0;
    slave_req  = 4'b0011;
    master_gnt = 1'b1;
    tick();
    tick();
    slave_add[1] = 32'h111;
    slave_add[3] = 32'h333;
    slave_req    = 4'b1010;
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (err_o !== 1'b0 || slave_gnt !== 4'b0000) begin
      errors++; $display("FAIL midreset_outputs: got err=%b gnt=%b expected err=0 gnt=0000", err_o, slave_gnt);
    end
    checks++;
    if (master_add !== 32'h111 || master_req !== 1'b1) begin
      errors++; $display("FAIL midreset_prio: got add=%h req=%b expected add=111 req=1", master_add, master_req);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    slave_req = 4'b1000;
    @(negedge clk_i);
    checks++;
    if (slave_gnt !== 4'b1000) begin
      errors++; $display("FAIL midreset_first: got %b expected 1000", slave_gnt);
    end
    tick();
    slave_req      = '0;
    master_gnt     = 1'b0;
    master_r_valid = 1'b1;
    @(negedge clk_i);
    checks++;
    if (slave_r_valid !== 4'b1000) begin
      errors++; $display("FAIL midreset_resp: got %b expected 1000", slave_r_valid);
    end
    tick();
    @(negedge clk_i);
    checks++;
    if (slave_r_valid !== 4'b0000) begin
      errors++; $display("FAIL midreset_stale: got %b expected 0000", slave_r_valid);
    end
    tick();
    master_r_valid = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_random();
    int w;
    logic [NB-1:0]                        e_gnt, e_rv;
    logic                                 e_req;
    logic [AW+1+DW+DW/8+1+UW-1:0]         e_mf, a_mf;
    logic [NB-1:0][DW-1:0]                e_rd;
    logic [NB-1:0]                        e_ro;
    logic [NB-1:0][UW-1:0]                e_ru;
    for (int c = 0; c < 400; c++) begin
      slave_req      = 4'($urandom);
      master_gnt     = ($urandom_range(0, 9) < 7);
      master_r_valid = ($urandom_range(0, 9) < 4);
      master_r_data  = $urandom;
      master_r_opc   = 1'($urandom);
      master_r_user  = 2'($urandom);
      clear_i        = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NB; i++) begin
        slave_add[i]  = $urandom;
        slave_wen[i]  = 1'($urandom);
        slave_data[i] = $urandom;
        slave_be[i]   = 4'($urandom);
        slave_lrdy[i] = 1'($urandom);
        slave_user[i] = 2'($urandom);
      end
      @(negedge clk_i);
      w     = model_winner(slave_req, m_prio);
      e_req = (w >= 0) && (m_q.size() < MO);
      e_gnt = (e_req && master_gnt) ? (ONE << w) : '0;
      e_mf  = '0;
      if (w >= 0) e_mf = {slave_add[w], slave_wen[w], slave_data[w], slave_be[w], slave_lrdy[w], slave_user[w]};
      a_mf  = {master_add, master_wen, master_data, master_be, master_lrdy, master_user};
      e_rv = '0; e_rd = '0; e_ro = '0; e_ru = '0;
      if (master_r_valid && m_q.size() > 0) begin
        e_rv[m_q[0]] = 1'b1;
        e_rd[m_q[0]] = master_r_data;
        e_ro[m_q[0]] = master_r_opc;
        e_ru[m_q[0]] = master_r_user;
      end
      checks++;
      if (master_req !== e_req) begin
        errors++; $display("FAIL rand_req[%0d]: got %b expected %b", c, master_req, e_req);
      end
      checks++;
      if (slave_gnt !== e_gnt) begin
        errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", c, slave_gnt, e_gnt);
      end
      checks++;
      if (a_mf !== e_mf) begin
        errors++; $display("FAIL rand_master_fields[%0d]: got %h expected %h", c, a_mf, e_mf);
      end
      checks++;
      if (slave_r_valid !== e_rv) begin
        errors++; $display("FAIL rand_r_valid[%0d]: got %b expected %b", c, slave_r_valid, e_rv);
      end
      checks++;
      if ({slave_r_data, slave_r_opc, slave_r_user} !== {e_rd, e_ro, e_ru}) begin
        errors++; $display("FAIL rand_r_fields[%0d]: got %h expected %h", c,
                           {slave_r_data, slave_r_opc, slave_r_user}, {e_rd, e_ro, e_ru});
      end
      checks++;
      if (err_o !== exp_err()) begin
        errors++; $display("FAIL rand_err[%0d]: got %b expected %b", c, err_o, exp_err());
      end
      tick();
    end
    clear_i = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_full_fifo();
    test_routing();
    test_orphan();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1);
  end

endmodule

// File: doc/hci_core_per_arbiter.md
HCI_CORE_PER_ARBITER -- requirements
Module: hci_core_per_arbiter

Interface
REQ-001 The block SHALL have parameter NB_IN, default 4: number of requester ports (2..16).
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4: depth of the response-routing FIFO (power of two, >=2).
REQ-003 The block SHALL have parameter AW, default hci_package::DEFAULT_AW: address width, passed through unchanged.
REQ-004 The block SHALL have port clk_i, input, 1 bit: single clock, all state on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port clear_i, input, 1 bit: synchronous clear, same effect as reset.
REQ-007 The block SHALL have port slave[NB_IN], hci_core_intf.slave: requester ports.
REQ-008 The block SHALL have port master, hci_core_intf.master: shared peripheral port.
REQ-009 The block SHALL have port err_o, output, 1 bit: sticky orphan-response flag.

Function
REQ-010 The block SHALL drive master.req = OR of all slave[i].req when the FIFO is not full, else 0.
REQ-011 The block SHALL select the winner combinationally by round-robin: first requesting index at or after prio_q, wrapping modulo NB_IN.
REQ-012 The block SHALL route add, wen, data, be, lrdy and user of the winner to master; with no request, master fields SHALL be 0.
REQ-013 The block SHALL assert slave[winner].gnt = master.gnt & master.req; all other slave gnt SHALL be 0.
REQ-014 On handshake (master.req & master.gnt), the block SHALL push the winner index into the FIFO and set prio_q = (winner+1) mod NB_IN at the next edge.
REQ-015 Without a handshake, prio_q SHALL hold its value.
REQ-016 Every accepted transaction, read or write, SHALL be tracked for exactly one master.r_valid pulse.
REQ-017 On master.r_valid with the FIFO non-empty, the block SHALL pop the head and drive slave[head] r_valid, r_data, r_opc and r_user from master in the same cycle (0-cycle response latency).
REQ-018 All non-addressed slave r_* outputs SHALL be 0.
REQ-019 Simultaneous push and pop SHALL leave the count unchanged; this SHALL be legal at count = MAX_OUTSTANDING (pop frees the slot in the same cycle, but REQ-010 still blocks the request that cycle).
REQ-020 Pointer wrap: read and write pointers SHALL wrap modulo MAX_OUTSTANDING; count SHALL be MAX_OUTSTANDING+1 states wide.
REQ-021 master.r_valid with an empty FIFO SHALL be dropped: no slave r_valid, and FIFO state unchanged.
REQ-022 Request-side paths SHALL be purely combinational; the only state SHALL be prio_q, the FIFO and err_o.

Reset
REQ-023 On rst_i high, or on clear_i at an edge, the block SHALL set prio_q = 0, empty the FIFO (pointers and count 0) and set err_o = 0.
REQ-024 Reset or clear mid-transaction SHALL discard outstanding routing entries; later orphan responses SHALL follow REQ-021.
REQ-025 While in reset, the block SHALL drive all slave gnt and r_valid outputs to 0.

Configuration
REQ-026 Macro HCI_PER_ARB_ERR_EN: when defined, err_o SHALL set on any REQ-021 event and stay set until reset or clear.
REQ-027 When HCI_PER_ARB_ERR_EN is undefined, err_o SHALL be tied to 0 and no flag flop SHALL exist.

Verification
REQ-028 Fairness: NB_IN=4, all four req held, master.gnt=1 every cycle, r_valid one cycle later -> grants in order 0,1,2,3,0.
REQ-029 Full FIFO: MAX_OUTSTANDING=4, gnt=1 and no r_valid -> four handshakes, then master.req=0; one r_valid then re-enables req on the following cycle.
REQ-030 Routing: slave2 reads 0x100 and slave0 reads 0x200, responses 0xAAAA then 0xBBBB -> slave2 gets 0xAAAA and slave0 gets 0xBBBB, each with exactly one r_valid.
REQ-031 Orphan: r_valid with an empty FIFO -> no slave r_valid, and err_o=1 only with HCI_PER_ARB_ERR_EN defined.
REQ-032 Reset mid-flight: two outstanding, assert rst_i asynchronously -> count=0, prio_q=0, err_o=0 immediately; subsequent request from slave3 granted first.
